rcb_frl_crc_engine: RTL

- Streaming, parametrised CRC engine for the Fast Radio Link.
- It replaces fixed-width, purely combinational CRC-8 generation over a 48-bit word with a framed, word-serial generator/checker.
- Polynomial, CRC width, data width and init value are all configurable.
- It sits beside the FRL TX packer (generate mode: produces the CRC to append) and the RX unpacker (check mode: flags corrupted frames).

---
 rtl/rcb_frl_crc_engine_if.sv | 28 ++
 rtl/rcb_frl_crc_engine.sv | 122 ++++++++++++
 2 files changed

// File: rtl/rcb_frl_crc_engine_if.sv
// Word-serial stream into the FRL CRC engine and its per-frame result.
// The engine connects through the slave modport; the packer/unpacker side uses master.
interface rcb_frl_crc_engine_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CRC_W  = 8,
  parameter int unsigned LEN_W  = 8
);
  logic              MODE;
  logic              IN_VALID;
  logic              IN_SOF;
  logic              IN_EOF;
  logic [DATA_W-1:0] IN_DATA;
  logic              IN_READY;
  logic [CRC_W-1:0]  CRC_OUT;
  logic              CRC_VALID;
  logic              CRC_ERR;
  logic [LEN_W-1:0]  WORD_CNT;

  modport master (
    output MODE, IN_VALID, IN_SOF, IN_EOF, IN_DATA,
    input  IN_READY, CRC_OUT, CRC_VALID, CRC_ERR, WORD_CNT
  );

  modport slave (
    input  MODE, IN_VALID, IN_SOF, IN_EOF, IN_DATA,
    output IN_READY, CRC_OUT, CRC_VALID, CRC_ERR, WORD_CNT
  );
endinterface

// File: rtl/rcb_frl_crc_engine.sv
// Framed, word-serial CRC generator/checker for the Fast Radio Link.
// One word per cycle inside a frame; one result cycle (DONE) after each EOF beat.
module rcb_frl_crc_engine #(
  parameter int unsigned           DATA_W = 8,
  parameter int unsigned           CRC_W  = 8,
  parameter logic [CRC_W-1:0]      POLY   = 8'h07,
  parameter logic [CRC_W-1:0]      INIT   = 8'h00,
  parameter int unsigned           LEN_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  rcb_frl_crc_engine_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [CRC_W-1:0]   crc_q;
  logic [LEN_W-1:0]   cnt_q;
  logic               mode_q;
  logic               ready_q;
  logic [CRC_W-1:0]   crc_out_q;
  logic               valid_q;
  logic               err_q;
  logic [LEN_W-1:0]   word_cnt_q;

  logic               accept;
  logic               take_beat;
  logic [CRC_W-1:0]   crc_base_d;
  logic [CRC_W-1:0]   crc_d;
  logic [LEN_W-1:0]   cnt_d;
  logic               mode_d;

  // MSB-first, non-reflected CRC over one full word, unrolled by the loop.
  function automatic logic [CRC_W-1:0] step(input logic [CRC_W-1:0] c_in,
                                            input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = c_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ d[i];
      c  = (c << 1) ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  assign accept = bus.IN_VALID & ready_q;

  // A SOF beat always restarts from INIT; non-SOF beats only count while in RUN.
  assign take_beat = accept & (bus.IN_SOF | (state_q == RUN));

  always_comb begin
    crc_base_d = INIT;
    if ((state_q == RUN) && !bus.IN_SOF) begin
      crc_base_d = crc_q;
    end
    crc_d = step(crc_base_d, bus.IN_DATA);

    cnt_d  = LEN_W'(1);
    mode_d = bus.MODE;
    if (!bus.IN_SOF) begin
      cnt_d  = (cnt_q == {LEN_W{1'b1}}) ? cnt_q : cnt_q + LEN_W'(1);
      mode_d = mode_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      crc_q      <= INIT;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      ready_q    <= 1'b0;
      crc_out_q  <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      case (state_q)
        IDLE, RUN: begin
          if (take_beat) begin
            crc_q  <= crc_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            if (bus.IN_EOF) begin
              // Results are registered here so they appear during DONE and then hold.
              state_q    <= DONE;
              ready_q    <= 1'b0;
              valid_q    <= 1'b1;
              crc_out_q  <= crc_d;
              err_q      <= mode_d & (|crc_d);
              word_cnt_q <= cnt_d;
            end else begin
              state_q <= RUN;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          crc_q   <= INIT;
        end
        default: begin
          state_q <= IDLE;
          crc_q   <= INIT;
        end
      endcase
    end
  end

  assign bus.IN_READY  = ready_q;
  assign bus.CRC_OUT   = crc_out_q;
  assign bus.CRC_VALID = valid_q;
  assign bus.CRC_ERR   = err_q;
  assign bus.WORD_CNT  = word_cnt_q;

endmodule
